rom_stream_reader: RTL and testbench



---
 rtl/rom_stream_reader_if.sv | 30 +++
 rtl/rom_stream_reader.sv | 178 +++++++++++++++++
 tb/tb_rom_stream_reader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_stream_reader_if.sv
// ============================================================================
// Module  : rom_stream_reader_if
// Brief   : ROM read port plus valid/ready output stream of rom_stream_reader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rom_stream_reader_if #(
    parameter int AW = 4,
    parameter int DW = 4
);
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    // master: the reader (drives ROM request and stream); slave: ROM + consumer
    modport master (
        output rom_en, rom_addr, out_data, out_valid,
        input  rom_data, out_ready
    );
    modport slave (
        input  rom_en, rom_addr, out_data, out_valid,
        output rom_data, out_ready
    );
endinterface

`default_nettype wire

// File: rtl/rom_stream_reader.sv
// ============================================================================
// Module  : rom_stream_reader
// Brief   : Plays a ROM address window out as a valid/ready stream through a
//           2-entry buffer. Optional running checksum: ROM_STREAM_CSUM_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_stream_reader #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire                start,
    input  wire                abort,
    input  wire [AW-1:0]       start_addr,
    input  wire [AW:0]         len,
    output logic               busy,
    output logic               done,
`ifdef ROM_STREAM_CSUM_EN
    output logic [DW-1:0]      csum,
`endif
    rom_stream_reader_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          rom_en_q, rom_en_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          pend_q, pend_d;
    logic [DW-1:0] head_q, head_d;
    logic          head_v_q, head_v_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          skid_v_q, skid_v_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   issued_q, issued_d;
    logic [AW:0]   popped_q, popped_d;
    logic [DW-1:0] csum_q, csum_d;

    logic          w_pop;
    logic [1:0]    w_occ;

    // The output register is the buffer head; skid_q is the second entry.
    assign w_pop = head_v_q & bus.out_ready;

    always_comb begin
        state_d    = state_q;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        pend_d     = rom_en_q;
        head_d     = head_q;
        head_v_d   = head_v_q;
        skid_d     = skid_q;
        skid_v_d   = skid_v_q;
        len_d      = len_q;
        issued_d   = issued_q;
        popped_d   = popped_q;
        csum_d     = csum_q;
        w_occ      = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d    = len;
                    popped_d = '0;
                    csum_d   = '0;
                    if (len == '0) begin
                        issued_d = '0;
                        state_d  = S_DONE;
                    end else begin
                        issued_d   = {{AW{1'b0}}, 1'b1};
                        rom_en_d   = 1'b1;
                        rom_addr_d = start_addr;
                        state_d    = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    head_v_d = 1'b0;
                    skid_v_d = 1'b0;
                    pend_d   = 1'b0;
                    csum_d   = '0;
                    state_d  = S_IDLE;
                end else begin
                    if (w_pop) begin
                        head_v_d = skid_v_q;
                        head_d   = skid_v_q ? skid_q : head_q;
                        skid_v_d = 1'b0;
                        popped_d = popped_q + {{AW{1'b0}}, 1'b1};
                        csum_d   = csum_q + head_q;
                    end
                    if (pend_q) begin
                        if (!head_v_d) begin
                            head_v_d = 1'b1;
                            head_d   = bus.rom_data;
                        end else begin
                            skid_v_d = 1'b1;
                            skid_d   = bus.rom_data;
                        end
                    end
                    // Request still in flight counts against buffer space.
                    w_occ = {1'b0, head_v_d} + {1'b0, skid_v_d} + {1'b0, rom_en_q};
                    if ((issued_q < len_q) && (w_occ < 2'd2)) begin
                        rom_en_d   = 1'b1;
                        rom_addr_d = rom_addr_q + {{(AW-1){1'b0}}, 1'b1};
                        issued_d   = issued_q + {{AW{1'b0}}, 1'b1};
                    end
                    if (popped_d == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            pend_q     <= 1'b0;
            head_q     <= '0;
            head_v_q   <= 1'b0;
            skid_q     <= '0;
            skid_v_q   <= 1'b0;
            len_q      <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            pend_q     <= pend_d;
            head_q     <= head_d;
            head_v_q   <= head_v_d;
            skid_q     <= skid_d;
            skid_v_q   <= skid_v_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            csum_q     <= csum_d;
        end
    end

    assign bus.rom_en    = rom_en_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.out_data  = head_q;
    assign bus.out_valid = head_v_q;
    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);

`ifdef ROM_STREAM_CSUM_EN
    assign csum = csum_q;
`else
    logic w_csum_unused;
    assign w_csum_unused = ^csum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
// ============================================================================
// Module  : tb_rom_stream_reader
// Brief   : Randomised self-checking bench for rom_stream_reader against a
//           queue-based model of the expected address and data sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_stream_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] start_addr;
    logic [4:0] len;
    logic       busy;
    logic       done;
`ifdef ROM_STREAM_CSUM_EN
    logic [3:0] csum;
`endif

    rom_stream_reader_if #(.AW(4), .DW(4)) bus ();

    rom_stream_reader #(.AW(4), .DW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
`ifdef ROM_STREAM_CSUM_EN
        .csum       (csum),
`endif
        .bus        (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: mem[a] = ~a, one-cycle registered read; junk when not requested
    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= ~bus.rom_addr;
        else            bus.rom_data <= 4'($urandom);
    end

    int n_chk  = 0;
    int n_fail = 0;
    int n_iss  = 0;
    int n_pop  = 0;
    int done_cnt = 0;
    int rdy_mode = 0;
    int rdy_hold = 0;
    logic [3:0] exp_addr[$];
    logic [3:0] exp_data[$];
    logic [3:0] exp_sum;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Consumer ready: 0 always ready, 1 random, 2 low for rdy_hold cycles
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                1: bus.out_ready = 1'($urandom);
                2: begin
                    if (rdy_hold > 0) begin
                        bus.out_ready = 1'b0;
                        rdy_hold--;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: every ROM request and every pop is matched against the model
    initial begin
        logic       prev_stall = 1'b0;
        logic       prev_kill  = 1'b0;
        logic       prev_done  = 1'b0;
        logic [3:0] prev_data  = '0;
        forever begin
            @(negedge clk);
            if (exp_addr.size() == 0) begin
                check("rom_en_idle", bus.rom_en, 0);
            end else if (bus.rom_en) begin
                n_iss++;
                check("rom_addr", bus.rom_addr, exp_addr.pop_front());
                check("inflight_le2", (n_iss - n_pop) <= 2, 1);
            end
            if (prev_stall && !prev_kill) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, prev_data);
            end
            if (exp_data.size() == 0) begin
                check("pop_idle", bus.out_valid & bus.out_ready, 0);
            end else if (bus.out_valid && bus.out_ready) begin
                n_pop++;
                check("out_data", bus.out_data, exp_data.pop_front());
            end
            if (done) begin
                done_cnt++;
                check("done_single", prev_done, 0);
                check("done_busy", busy, 0);
            end
            prev_stall = bus.out_valid & ~bus.out_ready;
            prev_data  = bus.out_data;
            prev_kill  = abort | ~rst_n;
            prev_done  = done;
        end
    end

    task automatic launch(input logic [3:0] sa, input logic [4:0] ln);
        logic [3:0] a;
        exp_sum = '0;
        for (int i = 0; i < int'(ln); i++) begin
            a = sa + 4'(i);
            exp_addr.push_back(a);
            exp_data.push_back(~a);
            exp_sum = exp_sum + ~a;
        end
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = sa;
        len        = ln;
        @(posedge clk);
        #1;
        start      = 1'b0;
        start_addr = 4'($urandom);
        len        = 5'($urandom);
    endtask

    task automatic wait_done(input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 300) begin
            tick();
            k++;
        end
        check("done_count", done_cnt - d0, 1);
        check("busy_at_done", busy, 0);
        check("addr_left", exp_addr.size(), 0);
        check("data_left", exp_data.size(), 0);
`ifdef ROM_STREAM_CSUM_EN
        check("csum", csum, exp_sum);
`endif
        tick();
        check("done_low", done, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        int d0;
        int p0;
        int i0;
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        start_addr = '0;
        len = '0;
        repeat (3) @(posedge clk);
        tick();
        check("reset_state", {bus.rom_en, bus.rom_addr, bus.out_valid, bus.out_data, busy, done}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic run with latency check
        rdy_mode = 0;
        d0 = done_cnt;
        launch(4'd2, 5'd3);
        tick();
        check("lat_rom_en_c1", bus.rom_en, 1);
        check("lat_busy_c1", busy, 1);
        tick();
        check("lat_valid_c2", bus.out_valid, 0);
        tick();
        check("lat_valid_c3", bus.out_valid, 1);
        check("lat_data_c3", bus.out_data, 4'hD);
        wait_done(d0);

        // Address wrap
        d0 = done_cnt;
        launch(4'd14, 5'd4);
        wait_done(d0);

        // Backpressure: ready held low after start
        rdy_hold = 6;
        rdy_mode = 2;
        d0 = done_cnt;
        i0 = n_iss;
        launch(4'd0, 5'd8);
        repeat (4) tick();
        check("bp_issue_le2", (n_iss - i0) <= 2, 1);
        check("bp_valid", bus.out_valid, 1);
        check("bp_data", bus.out_data, 4'hF);
        wait_done(d0);
        rdy_mode = 0;

        // Zero-length run
        d0 = done_cnt;
        launch(4'd9, 5'd0);
        tick();
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        wait_done(d0);

        // Abort after the second pop
        d0 = done_cnt;
        p0 = n_pop;
        launch(4'd6, 5'd10);
        k = 0;
        while ((n_pop - p0) < 2 && k < 100) begin
            tick();
            k++;
        end
        check("abort_two_pops", (n_pop - p0) >= 2, 1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        n_pop = n_iss;
        tick();
        check("abort_busy", busy, 0);
        check("abort_valid", bus.out_valid, 0);
`ifdef ROM_STREAM_CSUM_EN
        check("abort_csum", csum, 0);
`endif
        repeat (3) tick();
        check("abort_no_done", done_cnt - d0, 0);
        d0 = done_cnt;
        launch(4'd5, 5'd1);
        wait_done(d0);

        // start during RUN must be ignored
        rdy_mode = 1;
        d0 = done_cnt;
        launch(4'd3, 5'd12);
        repeat (5) tick();
        @(posedge clk);
        #1;
        start = 1'b1;
        start_addr = 4'd9;
        len = 5'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(d0);

        // Randomised runs
        for (int r = 0; r < 8; r++) begin
            d0 = done_cnt;
            launch(4'($urandom), 5'($urandom_range(0, 16)));
            wait_done(d0);
        end

        // Reset mid-run
        d0 = done_cnt;
        launch(4'd7, 5'd9);
        repeat (6) tick();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        tick();
        check("midrun_reset", {bus.rom_en, bus.rom_addr, bus.out_valid, bus.out_data, busy, done}, 0);
`ifdef ROM_STREAM_CSUM_EN
        check("midrun_csum", csum, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        n_pop = n_iss;
        check("midrun_no_done", done_cnt - d0, 0);
        rdy_mode = 0;
        d0 = done_cnt;
        launch(4'd1, 5'd5);
        wait_done(d0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
